// File: rtl/chol_mac_seq.sv
// Cholesky MAC sequencer: walks one dot-product term at a time through a
// 1-cycle operand buffer and a pipelined MAC, feeding the running sum back on C.
module chol_mac_seq #(
  parameter int MAC_LATENCY = 4,
  parameter int ADDR_W      = 8,
  parameter int LEN_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_b,
  input  logic [63:0]       c_init,
  input  logic              sub,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [31:0]       rd_data_a,
  input  logic [31:0]       rd_data_b,
  output logic              mac_clken,
  output logic              mac_sclr,
  output logic [31:0]       mac_a,
  output logic [31:0]       mac_b,
  output logic [63:0]       mac_c,
  output logic              mac_sub,
  input  logic [63:0]       mac_p,
  output logic              busy,
  output logic              done,
  output logic [63:0]       result
);

  localparam int WC_W = $clog2(MAC_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              sub_q;
  logic [63:0]       acc;
  logic [WC_W-1:0]   wcnt;

  logic [LEN_W-1:0]  k_inc;
  logic [ADDR_W-1:0] addr_a_inc;
  logic [ADDR_W-1:0] addr_b_inc;

  assign k_inc      = k + LEN_W'(1);
  assign addr_a_inc = addr_a + ADDR_W'(1);
  assign addr_b_inc = addr_b + stride_b_q_w();

  function automatic logic [ADDR_W-1:0] stride_b_q_w();
    return stride_q;
  endfunction

  // Outputs are set on the edge that enters the state they belong to, so each
  // branch below programs the outputs of the state it is moving to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      k         <= '0;
      stride_q  <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      sub_q     <= 1'b0;
      acc       <= '0;
      wcnt      <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      mac_clken <= 1'b0;
      mac_sclr  <= 1'b1;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      mac_sub   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        mac_clken <= 1'b0;
        mac_sclr  <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len_q    <= len;
              stride_q <= stride_b;
              sub_q    <= sub;
              acc      <= c_init;
              k        <= '0;
              addr_a   <= base_a;
              addr_b   <= base_b;
              busy     <= 1'b1;
              mac_sclr <= 1'b0;
              if (len == '0) begin
                state  <= S_DONE;
                done   <= 1'b1;
                result <= c_init;
              end else begin
                state     <= S_READ;
                rd_en     <= 1'b1;
                rd_addr_a <= base_a;
                rd_addr_b <= base_b;
              end
            end
          end
          S_READ: begin
            state     <= S_ISSUE;
            mac_clken <= 1'b1;
          end
          S_ISSUE: begin
            mac_a   <= rd_data_a;
            mac_b   <= rd_data_b;
            mac_c   <= acc;
            mac_sub <= sub_q;
            wcnt    <= WC_W'(MAC_LATENCY);
            state   <= S_WAIT;
          end
          S_WAIT: begin
            wcnt <= wcnt - WC_W'(1);
            if (wcnt == WC_W'(1)) begin
              acc       <= mac_p;
              k         <= k_inc;
              addr_a    <= addr_a_inc;
              addr_b    <= addr_b_inc;
              mac_clken <= 1'b0;
              if (k_inc == len_q) begin
                state  <= S_DONE;
                done   <= 1'b1;
                result <= mac_p;
              end else begin
                state     <= S_READ;
                rd_en     <= 1'b1;
                rd_addr_a <= addr_a_inc;
                rd_addr_b <= addr_b_inc;
              end
            end
          end
          S_DONE: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            mac_sclr <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            mac_clken <= 1'b0;
            mac_sclr  <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chol_mac_seq.sv
// Bench for chol_mac_seq: operand buffer and pipelined MAC models around the
// DUT, results checked against a plain-arithmetic dot-product model.
module tb_chol_mac_seq;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, sub;
  logic [7:0]  len, base_a, base_b, stride_b;
  logic [63:0] c_init;
  logic        rd_en;
  logic [7:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        mac_clken, mac_sclr, mac_sub;
  logic [31:0] mac_a, mac_b;
  logic [63:0] mac_c, mac_p;
  logic        busy, done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [63:0] pipe  [0:L-2];

  always #5 clk = ~clk;

  chol_mac_seq #(.MAC_LATENCY(L), .ADDR_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .base_a(base_a), .base_b(base_b), .stride_b(stride_b), .c_init(c_init),
    .sub(sub), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .mac_clken(mac_clken),
    .mac_sclr(mac_sclr), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_sub(mac_sub), .mac_p(mac_p), .busy(busy), .done(done), .result(result)
  );

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  // MAC model: P emerges a few enabled edges after sampling A/B/C
  always @(posedge clk) begin
    if (mac_sclr) begin
      for (int i = 0; i < L - 1; i++) pipe[i] <= '0;
    end else if (mac_clken) begin
      pipe[0] <= mac_sub ? $signed(mac_c) - $signed(mac_a) * $signed(mac_b)
                         : $signed(mac_c) + $signed(mac_a) * $signed(mac_b);
      for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_p = pipe[L-2];

  function automatic logic [63:0] ref_dot(input int unsigned n, input logic [7:0] ba,
                                          input logic [7:0] bb, input logic [7:0] sb,
                                          input logic [63:0] c0, input logic s);
    logic [63:0] acc;
    logic signed [63:0] pa, pb;
    logic [7:0] ia, ib;
    acc = c0;
    for (int unsigned k = 0; k < n; k++) begin
      ia = 8'(ba + k);
      ib = 8'(bb + k * sb);
      pa = $signed(mem_a[ia]);
      pb = $signed(mem_b[ib]);
      acc = s ? acc - 64'(pa * pb) : acc + 64'(pa * pb);
    end
    return acc;
  endfunction

  int         obs_edges, obs_rd, obs_clk, obs_busy, obs_overlap;
  bit         obs_done;
  logic       obs_post_sclr, obs_post_busy, obs_post_clken;
  logic [7:0] obs_addrb [$];

  // kind: 0 none, 1 stray start at cycle inj_at, 2 abort at cycle inj_at
  task automatic run_op(input logic [7:0] n, input logic [7:0] ba, input logic [7:0] bb,
                        input logic [7:0] sb, input logic [63:0] c0, input logic s,
                        input int inj_at, input int kind);
    int cyc, limit;
    obs_edges = -1; obs_rd = 0; obs_clk = 0; obs_busy = 0; obs_overlap = 0;
    obs_done = 0; obs_addrb.delete();
    obs_post_sclr = 1'bx; obs_post_busy = 1'bx; obs_post_clken = 1'bx;
    limit = (kind == 2) ? inj_at + 20 : 200;
    @(negedge clk);
    len = n; base_a = ba; base_b = bb; stride_b = sb; c_init = c0; sub = s; start = 1'b1;
    cyc = 0;
    while (!obs_done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (rd_en) begin obs_rd++; obs_addrb.push_back(rd_addr_b); end
      if (mac_clken) obs_clk++;
      if (mac_clken && mac_sclr) obs_overlap++;
      if (done) begin obs_done = 1; obs_edges = cyc - 1; end
      else if (busy) obs_busy++;
      if (cyc == inj_at + 1) begin
        obs_post_sclr = mac_sclr; obs_post_busy = busy; obs_post_clken = mac_clken;
      end
      if (cyc == inj_at && kind == 1) begin
        start = 1'b1; len = 8'd1; base_a = 8'h99; base_b = 8'h77; stride_b = 8'd3;
        c_init = '1; sub = ~s;
      end
      if (cyc == inj_at && kind == 2) abort = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; base_a = '0; base_b = '0;
    stride_b = '0; c_init = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, mac_clken, busy, done, mac_sub} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {rd_en, mac_clken, busy, done, mac_sub});
    end
    checks++;
    if (mac_sclr !== 1'b1) begin errors++; $display("FAIL reset_sclr: got %b expected 1", mac_sclr); end
    checks++;
    if ({result, mac_c, mac_a, mac_b, rd_addr_a, rd_addr_b} !== '0) begin
      errors++; $display("FAIL reset_data: result %h mac_c %h expected 0", result, mac_c);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan_sub;
    mem_a[8'h10] = 2; mem_a[8'h11] = 3; mem_a[8'h12] = 4;
    mem_b[8'h20] = 5; mem_b[8'h21] = 6; mem_b[8'h22] = 7;
    run_op(8'd3, 8'h10, 8'h20, 8'd1, 64'd100, 1'b1, -10, 0);
    checks++;
    if (!obs_done) begin errors++; $display("FAIL plan_timeout: done never seen"); end
    checks++;
    if (result !== 64'd44) begin errors++; $display("FAIL plan_result: got %0d expected 44", result); end
    checks++;
    if (obs_edges != 18) begin errors++; $display("FAIL plan_done_time: got %0d expected 18", obs_edges); end
    checks++;
    if (obs_busy != 18) begin errors++; $display("FAIL plan_busy: got %0d expected 18", obs_busy); end
    checks++;
    if (obs_rd != 3) begin errors++; $display("FAIL plan_rd_en: got %0d expected 3", obs_rd); end
    checks++;
    if (obs_clk != 15 || obs_overlap != 0) begin
      errors++; $display("FAIL plan_clken: got %0d/%0d expected 15/0", obs_clk, obs_overlap);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, mac_sclr} !== 3'b001) begin
      errors++; $display("FAIL plan_after_done: got %b expected 001", {done, busy, mac_sclr});
    end
  endtask

  task automatic test_len_zero;
    run_op(8'd0, 8'h00, 8'h00, 8'd1, 64'h1234, 1'b0, -10, 0);
    checks++;
    if (obs_edges != 0) begin errors++; $display("FAIL len0_time: got %0d expected 0", obs_edges); end
    checks++;
    if (obs_rd != 0 || obs_clk != 0) begin
      errors++; $display("FAIL len0_activity: rd %0d clken %0d expected 0 0", obs_rd, obs_clk);
    end
    checks++;
    if (result !== 64'h1234) begin errors++; $display("FAIL len0_result: got %h expected 1234", result); end
  endtask

  task automatic test_wrap;
    mem_a[8'h30] = 32'hFFFFFFFD; mem_a[8'h31] = 32'h7FFFFFFF;
    mem_b[8'hFE] = 4; mem_b[8'hFF] = 2;
    run_op(8'd2, 8'h30, 8'hFE, 8'd1, '1, 1'b0, -10, 0);
    checks++;
    if (obs_addrb.size() != 2) begin
      errors++; $display("FAIL wrap_reads: got %0d expected 2", obs_addrb.size());
    end else begin
      checks++;
      if (obs_addrb[0] !== 8'hFE || obs_addrb[1] !== 8'hFF) begin
        errors++; $display("FAIL wrap_addr_b: got %h,%h expected fe,ff", obs_addrb[0], obs_addrb[1]);
      end
    end
    checks++;
    if (result !== 64'hFFFFFFF1) begin errors++; $display("FAIL wrap_result: got %h expected fffffff1", result); end
  endtask

  task automatic test_start_ignored;
    run_op(8'd3, 8'h10, 8'h20, 8'd1, 64'd100, 1'b1, 4, 1);
    checks++;
    if (result !== 64'd44 || obs_edges != 18) begin
      errors++; $display("FAIL busy_start: result %0d at %0d expected 44 at 18", result, obs_edges);
    end
    checks++;
    if (obs_rd != 3) begin errors++; $display("FAIL busy_start_reads: got %0d expected 3", obs_rd); end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic [63:0] exp;
    run_op(8'd3, 8'h10, 8'h20, 8'd1, 64'd7, 1'b0, 10, 2);
    checks++;
    if (obs_done) begin errors++; $display("FAIL abort_done: got done expected none"); end
    checks++;
    if ({obs_post_sclr, obs_post_busy, obs_post_clken} !== 3'b100) begin
      errors++; $display("FAIL abort_idle: got %b expected 100", {obs_post_sclr, obs_post_busy, obs_post_clken});
    end
    checks++;
    if (result !== 64'd44) begin errors++; $display("FAIL abort_result: got %0d expected 44", result); end
    exp = ref_dot(2, 8'h10, 8'h21, 8'd1, 64'd5, 1'b0);
    run_op(8'd2, 8'h10, 8'h21, 8'd1, 64'd5, 1'b0, -10, 0);
    checks++;
    if (result !== exp || obs_edges != 12) begin
      errors++; $display("FAIL abort_restart: got %0d at %0d expected %0d at 12", result, obs_edges, exp);
    end
  endtask

  task automatic test_reset_mid;
    mem_a[8'h40] = 6; mem_b[8'h41] = 7;
    @(negedge clk);
    len = 8'd3; base_a = 8'h10; base_b = 8'h20; stride_b = 8'd1; c_init = 64'd9; sub = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (mac_clken !== 1'b1) begin errors++; $display("FAIL rstmid_issue: clken %b expected 1", mac_clken); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_en, mac_clken, busy, done, mac_sclr} !== 5'b00001 || result !== '0 || mac_c !== '0) begin
      errors++; $display("FAIL rstmid_outputs: ctrl %b result %h expected 00001 0",
                         {rd_en, mac_clken, busy, done, mac_sclr}, result);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(8'd1, 8'h40, 8'h41, 8'd1, 64'd0, 1'b0, -10, 0);
    checks++;
    if (result !== 64'd42 || obs_edges != 6) begin
      errors++; $display("FAIL rstmid_after: got %0d at %0d expected 42 at 6", result, obs_edges);
    end
  endtask

  task automatic test_random;
    logic [7:0]  n, ba, bb, sb;
    logic [63:0] c0, exp;
    logic        s;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = $urandom; mem_b[i] = $urandom;
    end
    for (int it = 0; it < 10; it++) begin
      n = 8'($urandom_range(1, 6)); ba = 8'($urandom); bb = 8'($urandom);
      sb = 8'($urandom); c0 = {$urandom, $urandom}; s = 1'($urandom);
      exp = ref_dot(n, ba, bb, sb, c0, s);
      run_op(n, ba, bb, sb, c0, s, -10, 0);
      checks++;
      if (result !== exp) begin
        errors++; $display("FAIL rand_result[%0d]: got %h expected %h", it, result, exp);
      end
      checks++;
      if (obs_edges != int'(n) * (L + 2) || obs_rd != int'(n)) begin
        errors++; $display("FAIL rand_timing[%0d]: done %0d rd %0d expected %0d %0d",
                           it, obs_edges, obs_rd, int'(n) * (L + 2), n);
      end
    end
  endtask

  initial begin
    test_reset;
    test_plan_sub;
    test_len_zero;
    test_wrap;
    test_plan_sub;
    test_start_ignored;
    test_abort;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
